// File: rtl/deal_sequencer_pkg.sv
// rtl/deal_sequencer_pkg.sv - shared constants and state encoding for the opening-hand deal sequencer
// Purpose: state enum, card rank constants and hand-scoring constants used by
//          deal_sequencer and card_value_adder.
package deal_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_REQ_CARD     = 3'd1,
    ST_ADD          = 3'd2,
    ST_HOLD_REQ     = 3'd3,
    ST_HOLD_RELEASE = 3'd4,
    ST_DONE         = 3'd5,
    ST_ERROR        = 3'd6
  } state_t;

  localparam int RANK_ACE      = 1;
  localparam int RANK_FACE_MIN = 11;
  localparam int RANK_MAX      = 13;
  localparam int BJ_TARGET     = 21;
  localparam int FACE_VALUE    = 10;
  localparam int ACE_HIGH      = 11;
  // Demoting a soft ace from 11 to 1.
  localparam int SOFT_ADJUST   = 10;

  // Opening hand is four cards: player, dealer, player, dealer.
  localparam logic [1:0] LAST_CARD_IDX = 2'd3;

endpackage

// File: rtl/card_value_adder.sv
// rtl/card_value_adder.sv - combinational card scoring with soft-ace correction
// Purpose: adds one card rank to a hand total, tracking whether an ace is
//          still counted as 11.
// Ports:
//   rank     in   card rank code (1 = ace, 2..10, 11..13 = J/Q/K)
//   sum_in   in   current hand total
//   soft_in  in   hand currently holds an ace counted as 11
//   sum_out  out  new hand total
//   soft_out out  new soft flag
module card_value_adder #(
  parameter int CARD_W = 4,
  parameter int SUM_W  = 6
) (
  input  logic [CARD_W-1:0] rank,
  input  logic [SUM_W-1:0]  sum_in,
  input  logic              soft_in,
  output logic [SUM_W-1:0]  sum_out,
  output logic              soft_out
);
  import deal_sequencer_pkg::*;

  logic             is_ace;
  logic             soft_any;
  logic [SUM_W-1:0] card_val;
  logic [SUM_W-1:0] raw_sum;

  always_comb begin
    is_ace   = (rank == CARD_W'(RANK_ACE));
    card_val = SUM_W'(rank);
    if (is_ace) begin
      card_val = SUM_W'(ACE_HIGH);
    end else if (rank >= CARD_W'(RANK_FACE_MIN)) begin
      card_val = SUM_W'(FACE_VALUE);
    end
    raw_sum  = sum_in + card_val;
    soft_any = soft_in | is_ace;
    sum_out  = raw_sum;
    soft_out = soft_any;
    // A bust with an 11-valued ace in hand is rescued by counting it as 1.
    if (soft_any && (raw_sum > SUM_W'(BJ_TARGET))) begin
      sum_out  = raw_sum - SUM_W'(SOFT_ADJUST);
      soft_out = 1'b0;
    end
  end

endmodule

// File: rtl/deal_sequencer.sv
// rtl/deal_sequencer.sv - deals the opening BlackJack hand with a 2 s hold after each card
// Purpose: requests four cards (player, dealer, player, dealer), scores both
//          hands, and runs a four-phase hold handshake with the delay counter
//          after every card.
// Ports:
//   clk_50M        in   system clock
//   i_Reset_n      in   asynchronous active-low reset
//   i_Start        in   one-cycle pulse, accepted only in IDLE/DONE/ERROR
//   o_Card_Req     out  card request level to the card source
//   i_Card_Valid   in   card source acknowledge, i_Card valid while high
//   i_Card         in   card rank
//   o_TwoSec       out  hold request level to the delay counter
//   i_TwoSec_Done  in   hold-complete acknowledge
//   o_Player_Sum   out  player hand total
//   o_Dealer_Sum   out  dealer hand total
//   o_Card_Idx     out  index of the card being dealt (0..3)
//   o_Busy         out  deal in progress
//   o_Done         out  deal completed
//   o_Player_BJ    out  player holds 21 with two cards (valid in DONE)
//   o_Error        out  bad card rank or card source timeout
module deal_sequencer #(
  parameter int CARD_W       = 4,
  parameter int SUM_W        = 6,
  parameter int CARD_TIMEOUT = 1023
) (
  input  logic              clk_50M,
  input  logic              i_Reset_n,
  input  logic              i_Start,
  output logic              o_Card_Req,
  input  logic              i_Card_Valid,
  input  logic [CARD_W-1:0] i_Card,
  output logic              o_TwoSec,
  input  logic              i_TwoSec_Done,
  output logic [SUM_W-1:0]  o_Player_Sum,
  output logic [SUM_W-1:0]  o_Dealer_Sum,
  output logic [1:0]        o_Card_Idx,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Player_BJ,
  output logic              o_Error
);
  import deal_sequencer_pkg::*;

  localparam int TMO_W = $clog2(CARD_TIMEOUT + 1);
  // The counter value seen on the last permitted wait cycle; leaving that
  // cycle without a card means CARD_TIMEOUT cycles have elapsed.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CARD_TIMEOUT - 1);

  state_t            state;
  state_t            state_nx;
  logic [CARD_W-1:0] card_q;
  logic [SUM_W-1:0]  player_sum;
  logic [SUM_W-1:0]  dealer_sum;
  logic              player_soft;
  logic              dealer_soft;
  logic [1:0]        card_idx;
  logic              player_bj;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              start_ok;
  logic              card_bad;
  logic              hold_clear;
  logic              to_dealer;
  logic [SUM_W-1:0]  add_sum_in;
  logic [SUM_W-1:0]  add_sum_out;
  logic              add_soft_in;
  logic              add_soft_out;

  // Odd card positions belong to the dealer; one adder serves both hands.
  assign to_dealer   = card_idx[0];
  assign add_sum_in  = to_dealer ? dealer_sum  : player_sum;
  assign add_soft_in = to_dealer ? dealer_soft : player_soft;

  card_value_adder #(
    .CARD_W (CARD_W),
    .SUM_W  (SUM_W)
  ) u_adder (
    .rank     (card_q),
    .sum_in   (add_sum_in),
    .soft_in  (add_soft_in),
    .sum_out  (add_sum_out),
    .soft_out (add_soft_out)
  );

  assign o_Player_Sum = player_sum;
  assign o_Dealer_Sum = dealer_sum;
  assign o_Card_Idx   = card_idx;
  assign o_Player_BJ  = player_bj;

  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Request outputs decode straight from the state register so that reset
  // drops them without waiting for a clock edge.
  always_comb begin
    state_nx   = state;
    start_ok   = 1'b0;
    hold_clear = 1'b0;
    card_bad   = (i_Card == '0) || (i_Card > CARD_W'(RANK_MAX));
    o_Card_Req = 1'b0;
    o_TwoSec   = 1'b0;
    o_Busy     = 1'b1;
    o_Done     = 1'b0;
    o_Error    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        o_Busy  = 1'b0;
        o_Done  = (state == ST_DONE);
        o_Error = (state == ST_ERROR);
        if (i_Start) begin
          start_ok = 1'b1;
          state_nx = ST_REQ_CARD;
        end
      end
      ST_REQ_CARD: begin
        o_Card_Req = 1'b1;
        if (i_Card_Valid) begin
          state_nx = card_bad ? ST_ERROR : ST_ADD;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nx = ST_ERROR;
        end
      end
      ST_ADD: begin
        state_nx = ST_HOLD_REQ;
      end
      ST_HOLD_REQ: begin
        o_TwoSec = 1'b1;
        if (i_TwoSec_Done) begin
          state_nx = ST_HOLD_RELEASE;
        end
      end
      ST_HOLD_RELEASE: begin
        // Four-phase: the next card is not requested until Done has fallen.
        if (!i_TwoSec_Done) begin
          hold_clear = 1'b1;
          state_nx   = (card_idx == LAST_CARD_IDX) ? ST_DONE : ST_REQ_CARD;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50M or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      card_q      <= '0;
      player_sum  <= '0;
      dealer_sum  <= '0;
      player_soft <= 1'b0;
      dealer_soft <= 1'b0;
      card_idx    <= '0;
      player_bj   <= 1'b0;
      tmo_cnt     <= '0;
    end else if (start_ok) begin
      player_sum  <= '0;
      dealer_sum  <= '0;
      player_soft <= 1'b0;
      dealer_soft <= 1'b0;
      card_idx    <= '0;
      player_bj   <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        ST_REQ_CARD: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (i_Card_Valid) begin
            card_q <= i_Card;
          end
        end
        ST_ADD: begin
          if (to_dealer) begin
            dealer_sum  <= add_sum_out;
            dealer_soft <= add_soft_out;
          end else begin
            player_sum  <= add_sum_out;
            player_soft <= add_soft_out;
          end
        end
        ST_HOLD_RELEASE: begin
          if (hold_clear) begin
            tmo_cnt <= '0;
            if (card_idx == LAST_CARD_IDX) begin
              player_bj <= (player_sum == SUM_W'(BJ_TARGET));
            end else begin
              card_idx <= card_idx + 2'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
